// File: rtl/cluster_count_monitor_pkg.sv
// Shared constants, histogram binning and snapshot-handshake state type
// for the cluster count monitor.
package cluster_count_monitor_pkg;

  // Width of the per-cycle cluster count delivered by the upstream counter
  localparam int unsigned CNT_IN_W   = 8;
  // Cluster count above which a sample is treated as a high-occupancy crossing
  localparam int unsigned OVF_THRESH = 8;

  // Histogram bin edges: [0] ==0, [1] 1..4, [2] 5..8, [3] >8
  localparam int unsigned HIST_EDGE0 = 0;
  localparam int unsigned HIST_EDGE1 = 4;
  localparam int unsigned HIST_EDGE2 = 8;
  localparam int unsigned NUM_BINS   = 4;

  typedef enum logic [1:0] {
    BIN_ZERO = 2'd0,
    BIN_LOW  = 2'd1,
    BIN_MID  = 2'd2,
    BIN_HIGH = 2'd3
  } hist_bin_e;

  // Snapshot holding state: empty, or full and awaiting acknowledge
  typedef enum logic {
    SNAP_EMPTY = 1'b0,
    SNAP_FULL  = 1'b1
  } snap_state_e;

  // Map a cluster count onto its histogram bin
  function automatic hist_bin_e bin_of(input logic [CNT_IN_W-1:0] cnt);
    if (cnt == CNT_IN_W'(HIST_EDGE0)) begin
      return BIN_ZERO;
    end else if (cnt <= CNT_IN_W'(HIST_EDGE1)) begin
      return BIN_LOW;
    end else if (cnt <= CNT_IN_W'(HIST_EDGE2)) begin
      return BIN_MID;
    end else begin
      return BIN_HIGH;
    end
  endfunction

endpackage

// File: rtl/cluster_count_monitor_sat_counter.sv
// Saturating accumulator with synchronous clear. next_c is the value after
// applying this cycle's increment, so a window close can capture the closing
// sample while the register itself restarts from zero.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clock4x,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] inc,
  output logic [W-1:0] next_c
);

  logic [W-1:0] q;
  logic [W:0]   total_c;

  assign total_c = {1'b0, q} + {1'b0, inc};

  // Saturate at all-ones when the add carries out
  always_comb begin
    next_c = q;
    if (en) begin
      next_c = total_c[W] ? {W{1'b1}} : total_c[W-1:0];
    end
  end

  // Accumulator register; clear wins so the next window starts empty
  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      q <= next_c;
    end
  end

endmodule

// File: rtl/cluster_count_monitor.sv
// Cluster count monitor: accumulates per-window sum, maximum, overflow count
// and (optionally) an occupancy histogram of the registered cluster count,
// and hands each closed window to a consumer through a valid/ack snapshot.
// Optional histogram enabled by defining CLUSTER_HIST_EN.
module cluster_count_monitor
  import cluster_count_monitor_pkg::*;
#(
  parameter int unsigned WINDOW_BX = 4096,
  parameter int unsigned SUM_W     = 24,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                      clock4x,
  input  logic                      reset,
  input  logic [CNT_IN_W-1:0]       cnt_i,
  input  logic                      overflow_i,
  input  logic                      bx0_i,
  input  logic                      snap_ack_i,
  output logic                      snap_valid_o,
  output logic [SUM_W-1:0]          sum_o,
  output logic [CNT_IN_W-1:0]       max_o,
  output logic [CNT_W-1:0]          ovf_cnt_o,
  output logic [NUM_BINS*CNT_W-1:0] hist_o,
  output logic                      snap_lost_o
);

  localparam int unsigned BX_W = (WINDOW_BX > 1) ? $clog2(WINDOW_BX) : 1;
  localparam logic [BX_W-1:0] BX_LAST = BX_W'(WINDOW_BX - 1);

  logic [CNT_IN_W-1:0] cnt_q;
  logic                ovf_q;
  logic                bx0_q;
  logic                smp_vld_q;

  logic [1:0]          phase_q;
  logic [BX_W-1:0]     bx_q;
  logic [1:0]          smp_phase_c;
  logic                bx_step_c;
  logic                eow_c;

  logic [SUM_W-1:0]    sum_next_c;
  logic [CNT_W-1:0]    ovf_next_c;
  logic [CNT_IN_W-1:0] max_q;
  logic [CNT_IN_W-1:0] max_next_c;

  snap_state_e         state_q;
  snap_state_e         state_d;
  logic                load_c;
  logic                lost_set_c;

  // Input sample register; smp_vld_q marks that cnt_q holds a real sample
  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      bx0_q     <= 1'b0;
      smp_vld_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_i;
      ovf_q     <= overflow_i;
      bx0_q     <= bx0_i;
      smp_vld_q <= 1'b1;
    end
  end

  // A BX0 marker places its own sample at phase 0
  assign smp_phase_c = bx0_q ? 2'd0 : phase_q;
  assign bx_step_c   = smp_vld_q && (smp_phase_c == 2'd3);
  assign eow_c       = bx_step_c && (bx_q == BX_LAST);

  // Phase and BX counters locating the current sample inside the window
  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      phase_q <= 2'd0;
      bx_q    <= '0;
    end else begin
      if (smp_vld_q) begin
        phase_q <= smp_phase_c + 2'd1;
      end
      if (bx_step_c) begin
        bx_q <= (bx_q == BX_LAST) ? '0 : bx_q + BX_W'(1);
      end
    end
  end

  sat_counter #(.W(SUM_W)) u_sum (
    .clock4x (clock4x),
    .reset   (reset),
    .clr     (eow_c),
    .en      (smp_vld_q),
    .inc     (SUM_W'(cnt_q)),
    .next_c  (sum_next_c)
  );

  sat_counter #(.W(CNT_W)) u_ovf (
    .clock4x (clock4x),
    .reset   (reset),
    .clr     (eow_c),
    .en      (smp_vld_q & ovf_q),
    .inc     (CNT_W'(1)),
    .next_c  (ovf_next_c)
  );

  assign max_next_c = (smp_vld_q && (cnt_q > max_q)) ? cnt_q : max_q;

  // Running window maximum, restarted after the closing sample
  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      max_q <= '0;
    end else if (eow_c) begin
      max_q <= '0;
    end else begin
      max_q <= max_next_c;
    end
  end

  // Snapshot handshake state register
  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      state_q <= SNAP_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Decide load / drop / release of the snapshot
  always_comb begin
    state_d    = state_q;
    load_c     = 1'b0;
    lost_set_c = 1'b0;
    case (state_q)
      SNAP_EMPTY: begin
        if (eow_c) begin
          load_c  = 1'b1;
          state_d = SNAP_FULL;
        end
      end
      SNAP_FULL: begin
        if (eow_c) begin
          if (snap_ack_i) begin
            load_c = 1'b1;
          end else begin
            lost_set_c = 1'b1;
          end
        end else if (snap_ack_i) begin
          state_d = SNAP_EMPTY;
        end
      end
      default: state_d = SNAP_EMPTY;
    endcase
  end

  assign snap_valid_o = (state_q == SNAP_FULL);

  // Snapshot registers and sticky lost flag
  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      sum_o       <= '0;
      max_o       <= '0;
      ovf_cnt_o   <= '0;
      snap_lost_o <= 1'b0;
    end else begin
      if (load_c) begin
        sum_o     <= sum_next_c;
        max_o     <= max_next_c;
        ovf_cnt_o <= ovf_next_c;
      end
      snap_lost_o <= snap_lost_o | lost_set_c;
    end
  end

`ifdef CLUSTER_HIST_EN
  logic [1:0]                smp_bin_c;
  logic [NUM_BINS*CNT_W-1:0] hist_next_c;
  logic [NUM_BINS*CNT_W-1:0] hist_q;

  assign smp_bin_c = bin_of(cnt_q);

  for (genvar b = 0; b < NUM_BINS; b++) begin : g_hist
    sat_counter #(.W(CNT_W)) u_bin (
      .clock4x (clock4x),
      .reset   (reset),
      .clr     (eow_c),
      .en      (smp_vld_q && (smp_bin_c == 2'(b))),
      .inc     (CNT_W'(1)),
      .next_c  (hist_next_c[b*CNT_W +: CNT_W])
    );
  end

  // Histogram snapshot, loaded together with the other snapshot fields
  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
    end else if (load_c) begin
      hist_q <= hist_next_c;
    end
  end

  assign hist_o = hist_q;
`else
  assign hist_o = '0;
`endif

endmodule

// File: doc/cluster_count_monitor.md
CLUSTER_COUNT_MONITOR -- requirements
Module: cluster_count_monitor

Interface
REQ-001 Parameter WINDOW_BX, default 4096: window length in bunch crossings (BX); one BX is 4 clock4x cycles.
REQ-002 Parameter SUM_W, default 24: width of the per-window cluster-count sum.
REQ-003 Parameter CNT_W, default 16: width of the overflow counter and of each histogram counter.
REQ-004 Port clock4x  input  1: the single clock, 4x BX rate.
REQ-005 Port reset  input  1: reset, asynchronous and active-high.
REQ-006 Port cnt_i  input  8: per-cycle cluster count from the upstream cluster counter.
REQ-007 Port overflow_i  input  1: upstream overflow flag, aligned with cnt_i.
REQ-008 Port bx0_i  input  1: BX0 marker; resynchronises the phase counter.
REQ-009 Port snap_ack_i  input  1: consumer accepts the current snapshot.
REQ-010 Port snap_valid_o  output  1: a snapshot is held and not yet acknowledged.
REQ-011 Port sum_o  output  SUM_W: snapshot of the window sum.
REQ-012 Port max_o  output  8: snapshot of the window maximum.
REQ-013 Port ovf_cnt_o  output  CNT_W: snapshot of the window overflow count.
REQ-014 Port hist_o  output  4*CNT_W: snapshot histogram, bins [0] count==0, [1] 1-4, [2] 5-8, [3] >8.
REQ-015 Port snap_lost_o  output  1: sticky flag, a window closed while the previous snapshot was unacknowledged.

Function
REQ-016 cnt_i, overflow_i and bx0_i shall be registered once; all accumulation uses the registered sample.
REQ-017 The 2-bit phase counter shall increment every cycle and be forced to 0 on a registered sample with bx0 high.
REQ-018 The BX counter shall increment when phase==3, wrapping from WINDOW_BX-1 to 0.
REQ-019 End of window is the sample with phase==3 and BX counter==WINDOW_BX-1; that sample belongs to the closing window.
REQ-020 Per sample: sum += cnt (saturating at all-ones); max = max(max, cnt); ovf += overflow (saturating); the matching histogram bin += 1 (saturating).
REQ-021 At end of window, accumulators shall restart from the next sample, with no samples lost or double-counted.
REQ-022 At end of window with snap_valid_o low, or high with snap_ack_i high in the same cycle, snapshot registers shall load the final window values including that sample, and snap_valid_o shall be high the next cycle.
REQ-023 snap_valid_o shall rise 2 cycles after the last window sample is presented on cnt_i.
REQ-024 At end of window with snap_valid_o high and snap_ack_i low, snapshots shall be kept unchanged and snap_lost_o shall set and hold until reset.
REQ-025 snap_ack_i with snap_valid_o high and no end of window shall clear snap_valid_o the next cycle; snap_ack_i while snap_valid_o is low shall be ignored.
REQ-026 Snapshot outputs shall change only on a snapshot load.

Reset
REQ-027 Reset shall clear all registers, including phase, BX counter, accumulators, snapshots, snap_valid_o and snap_lost_o, to 0 immediately.
REQ-028 Reset mid-window shall discard the partial window; the first window after reset starts at phase 0, BX 0.

Configuration
REQ-029 Macro CLUSTER_HIST_EN: when defined, the histogram counters of REQ-020 and their snapshot are implemented.
REQ-030 When CLUSTER_HIST_EN is undefined, no histogram logic shall exist and hist_o shall be constant 0.

Structure
REQ-031 A shared package shall hold CNT_IN_W=8, OVF_THRESH=8, the histogram bin edges (0, 4, 8) and the bin-index enum.
REQ-032 One sub-module, sat_counter (parameterised width, increment, clear), shall implement every saturating counter and the sum.

Verification
REQ-033 WINDOW_BX=4, cnt=3 for 16 cycles -> sum_o=48, max_o=3, ovf=0, hist[1]=16, snap_valid_o high 2 cycles after the 16th sample.
REQ-034 cnt sequence 0, 9, 5, 2 repeated, overflow on 9 -> ovf_cnt_o=4 and hist bins 4/4/4/4 per 16-sample window; max_o=9.
REQ-035 No ack across two window ends -> first snapshot retained, snap_lost_o=1; ack together with the third window end -> third snapshot loaded, valid stays high.
REQ-036 SUM_W=8, cnt=255 -> sum_o saturates at 255; reset asserted mid-window -> all outputs 0 at once, next window counts from phase 0.
REQ-037 bx0_i pulse at phase 2 -> phase 0 on that sample, and the window end shifts accordingly; CLUSTER_HIST_EN undefined -> hist_o=0 in all scenarios.
